// File: rtl/bus_arbiter_pkg.sv
// Shared constants for the fetch/data bus arbiter: FSM state encoding and
// pipeline-wide bus constants.
package bus_arbiter_pkg;

    localparam int XLEN = 32;
    localparam int SELW = XLEN / 8;

    localparam logic [SELW-1:0] SEL_WORD  = '1;
    localparam logic [XLEN-1:0] ZERO_WORD = '0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_INST = 2'b01,
        ST_DATA = 2'b10
    } arb_state_e;

endpackage

// File: rtl/bus_arbiter.sv
// Two-master arbiter sharing one Wishbone master port between instruction
// fetch and data access, with starvation guard and transaction timeout.
//
// state | meaning
// IDLE  | no owner; grant evaluated every cycle
// INST  | instruction fetch owns the bus, waiting for i_wb_ack
// DATA  | data port owns the bus, waiting for i_wb_ack or cyc drop
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stb_inst,
    input  logic [XLEN-1:0] i_iaddr,
    output logic            o_ack_inst,
    output logic [XLEN-1:0] o_inst,
    input  logic            i_wb_cyc_data,
    input  logic            i_wb_stb_data,
    input  logic            i_wb_we_data,
    input  logic [XLEN-1:0] i_wb_addr_data,
    input  logic [XLEN-1:0] i_wb_data_data,
    input  logic [SELW-1:0] i_wb_sel_data,
    output logic            o_wb_ack_data,
    output logic            o_wb_stall_data,
    output logic [XLEN-1:0] o_wb_data_data,
    output logic            o_wb_cyc,
    output logic            o_wb_stb,
    output logic            o_wb_we,
    output logic [XLEN-1:0] o_wb_addr,
    output logic [XLEN-1:0] o_wb_data,
    output logic [SELW-1:0] o_wb_sel,
    input  logic            i_wb_ack,
    input  logic            i_wb_stall,
    input  logic [XLEN-1:0] i_wb_data,
    output logic            o_timeout
);

    localparam int SW = $clog2(STARVE_LIMIT + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
    localparam logic [TW-1:0] TMO_LOAD   = TW'(TIMEOUT_CYCLES - 1);

    arb_state_e    state;
    logic [SW-1:0] starve_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          data_req;
    logic          grant_inst;
    logic          grant_data;

    always_comb begin
        data_req   = i_wb_cyc_data && i_wb_stb_data;
        grant_inst = (state == ST_IDLE) && i_stb_inst &&
                     (!data_req || (starve_cnt == STARVE_MAX));
        grant_data = (state == ST_IDLE) && data_req && !grant_inst;
    end

    // Reset term keeps the data port stalled while the arbiter is held.
    assign o_wb_stall_data = i_rst || !grant_data;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state          <= ST_IDLE;
            starve_cnt     <= '0;
            tmo_cnt        <= '0;
            o_ack_inst     <= 1'b0;
            o_inst         <= '0;
            o_wb_ack_data  <= 1'b0;
            o_wb_data_data <= '0;
            o_wb_cyc       <= 1'b0;
            o_wb_stb       <= 1'b0;
            o_wb_we        <= 1'b0;
            o_wb_addr      <= '0;
            o_wb_data      <= '0;
            o_wb_sel       <= '0;
            o_timeout      <= 1'b0;
        end else begin
            o_ack_inst    <= 1'b0;
            o_wb_ack_data <= 1'b0;
            o_timeout     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    tmo_cnt <= '0;
                    if (grant_inst) begin
                        state      <= ST_INST;
                        starve_cnt <= '0;
                        tmo_cnt    <= TMO_LOAD;
                        o_wb_cyc   <= 1'b1;
                        o_wb_stb   <= 1'b1;
                        o_wb_we    <= 1'b0;
                        o_wb_addr  <= i_iaddr;
                        o_wb_data  <= ZERO_WORD;
                        o_wb_sel   <= SEL_WORD;
                    end else if (grant_data) begin
                        state     <= ST_DATA;
                        tmo_cnt   <= TMO_LOAD;
                        o_wb_cyc  <= 1'b1;
                        o_wb_stb  <= 1'b1;
                        o_wb_we   <= i_wb_we_data;
                        o_wb_addr <= i_wb_addr_data;
                        o_wb_data <= i_wb_data_data;
                        o_wb_sel  <= i_wb_sel_data;
                        if (i_stb_inst && (starve_cnt != STARVE_MAX))
                            starve_cnt <= starve_cnt + SW'(1);
                    end
                end
                ST_INST, ST_DATA: begin
                    // An ack arriving on the terminal cycle still completes normally.
                    if (i_wb_ack) begin
                        state    <= ST_IDLE;
                        tmo_cnt  <= '0;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                        if (state == ST_INST) begin
                            o_ack_inst <= 1'b1;
                            o_inst     <= i_wb_data;
                        end else begin
                            o_wb_ack_data  <= 1'b1;
                            o_wb_data_data <= i_wb_data;
                        end
                    end else if ((state == ST_DATA) && !i_wb_cyc_data) begin
                        state    <= ST_IDLE;
                        tmo_cnt  <= '0;
                        o_wb_cyc <= 1'b0;
                        o_wb_stb <= 1'b0;
                    end else if (tmo_cnt == '0) begin
                        state     <= ST_IDLE;
                        o_wb_cyc  <= 1'b0;
                        o_wb_stb  <= 1'b0;
                        o_timeout <= 1'b1;
                        if (state == ST_INST) begin
                            o_ack_inst <= 1'b1;
                            o_inst     <= ZERO_WORD;
                        end else begin
                            o_wb_ack_data  <= 1'b1;
                            o_wb_data_data <= ZERO_WORD;
                        end
                    end else begin
                        tmo_cnt <= tmo_cnt - TW'(1);
                        if (o_wb_stb && !i_wb_stall)
                            o_wb_stb <= 1'b0;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the number of consecutive data grants allowed while an instruction request waits.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 255: the number of cycles without i_wb_ack before a granted transaction is aborted.
REQ-003 The block SHALL have port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: the reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_stb_inst, input, 1 bit: instruction read request, held until o_ack_inst.
REQ-006 The block SHALL have port i_iaddr, input, 32 bits: instruction address.
REQ-007 The block SHALL have port o_ack_inst, output, 1 bit: a one-cycle pulse meaning o_inst is valid.
REQ-008 The block SHALL have port o_inst, output, 32 bits: the fetched instruction.
REQ-009 The block SHALL have port i_wb_cyc_data, input, 1 bit: data bus cycle active; deasserting it aborts the data transaction.
REQ-010 The block SHALL have ports i_wb_stb_data, input, 1 bit, and i_wb_we_data, input, 1 bit: data request and write-enable.
REQ-011 The block SHALL have ports i_wb_addr_data, input, 32 bits, and i_wb_data_data, input, 32 bits: data address and store data.
REQ-012 The block SHALL have port i_wb_sel_data, input, 4 bits: byte strobes.
REQ-013 The block SHALL have ports o_wb_ack_data, output, 1 bit, o_wb_stall_data, output, 1 bit, and o_wb_data_data, output, 32 bits: data ack pulse, data stall, and load data.
REQ-014 The block SHALL have ports o_wb_cyc, o_wb_stb and o_wb_we, outputs, 1 bit each: the shared memory master controls.
REQ-015 The block SHALL have ports o_wb_addr, output, 32 bits, o_wb_data, output, 32 bits, and o_wb_sel, output, 4 bits: the shared master address, data and byte strobes.
REQ-016 The block SHALL have ports i_wb_ack, input, 1 bit, i_wb_stall, input, 1 bit, and i_wb_data, input, 32 bits: the memory response.
REQ-017 The block SHALL have port o_timeout, output, 1 bit: a one-cycle pulse when a transaction times out.

Function
REQ-018 The FSM SHALL have the states IDLE, INST and DATA.
- From IDLE it SHALL move to INST or DATA on a grant; otherwise it stays in IDLE.
- The block SHALL allow exactly one outstanding transaction.
REQ-019 Grant in IDLE:
- Only i_stb_inst: grant INST.
- Only i_wb_cyc_data&&i_wb_stb_data: grant DATA.
- Both: grant DATA, unless the starve counter equals STARVE_LIMIT, in which case grant INST.
REQ-020 Starve counter:
- It SHALL increment on each DATA grant made while i_stb_inst=1, saturating at STARVE_LIMIT.
- It SHALL clear on every INST grant.
REQ-021 On grant, the requester's address, we, data and sel SHALL be latched.
- INST uses we=0 and sel=4'hF.
- These values SHALL drive o_wb_* from the first grant-state cycle until return to IDLE.
REQ-022 In the grant state, o_wb_cyc SHALL be 1.
- o_wb_stb SHALL be 1 until a cycle with o_wb_stb=1 and i_wb_stall=0, and 0 afterwards.
REQ-023 When i_wb_ack=1 in the grant state:
- i_wb_data SHALL be registered into o_inst or o_wb_data_data.
- The owner's ack SHALL be pulsed for exactly the next cycle.
- The FSM SHALL return to IDLE in that same next cycle.
- Minimum latency is request seen in IDLE at cycle N, owner ack at cycle N+3 with zero-wait memory.
REQ-024 o_wb_stall_data SHALL be combinational: 0 only when state=IDLE and DATA is being granted this cycle, 1 otherwise.
REQ-025 i_wb_ack in IDLE SHALL be ignored.
REQ-026 If the owner is DATA and i_wb_cyc_data falls before ack:
- o_wb_cyc and o_wb_stb SHALL drop the next cycle.
- No ack SHALL be issued.
- The FSM SHALL return to IDLE.
REQ-027 Timeout counter:
- It SHALL count cycles spent in INST or DATA and clear in IDLE.
- At TIMEOUT_CYCLES, the block SHALL drop o_wb_cyc, pulse o_timeout and the owner ack with data 32'h0 for one cycle, then return to IDLE.
REQ-028 If i_wb_ack and the timeout coincide, the ack SHALL win: normal data is returned and o_timeout stays 0.

Reset
REQ-029 While i_rst=1, asynchronously:
- The state SHALL be IDLE and both counters SHALL be 0.
- All outputs SHALL be 0 except o_wb_stall_data=1.
- Any in-flight transaction SHALL be abandoned without ack.
REQ-030 The first grant SHALL be possible in the first cycle after i_rst deasserts.

Structure
REQ-031 The FSM state encoding (2-bit IDLE/INST/DATA) SHALL live in the shared header with the existing pipeline constants.
REQ-032 The block SHALL be a single module with no sub-modules; the counters and FSM are inline.

Verification
REQ-033 Instruction only: i_iaddr=32'h100 with memory acking 1 cycle after stb -> o_wb_addr=32'h100, o_wb_we=0, o_wb_sel=4'hF, o_ack_inst one cycle with o_inst=i_wb_data.
REQ-034 Simultaneous requests held continuously with STARVE_LIMIT=4 -> grant order D,D,D,D,I,D,D,D,D,I.
REQ-035 i_wb_stall=1 for 3 cycles -> o_wb_stb held 4 cycles with the address stable; a single ack follows.
REQ-036 Data store, i_wb_cyc_data dropped before ack -> no o_wb_ack_data, o_wb_cyc=0 the next cycle, and an instruction granted afterwards.
REQ-037 No ack for TIMEOUT_CYCLES=8 -> o_timeout single pulse, owner ack with 32'h0, FSM back in IDLE.
REQ-038 i_rst asserted mid-DATA -> o_wb_cyc=0 immediately, no ack, and a clean grant after release.
